demux1to16_deframer: RTL
========================

// Module: demux1to16_deframer
// PURPOSE
//  Receive end of the 16-to-1 mux path. Takes the serial bit stream produced by sweeping a
//  16:1 mux select, routes each bit to its channel (registered 1-to-16 demux strobe) and
//  reassembles the full 16-bit word.
//  A completed word is handed downstream on a valid/ready interface. Sits directly after the
//  mux output in the comb-circuit datapath.
// PARAMETERS
//  N         16  channel count / reassembled word width (power of two, >=2)
//  SEL_W     4   select width, = log2(N)
//  AUTO_SEL  0   1: in_sel ignored, internal counter supplies select 0..N-1; 0: use in_sel
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous reset, active-high
//  flush      in   1      sync: discard partial word, clear channel mask and auto counter
//  in_valid   in   1      in_bit/in_sel valid this cycle
//  in_ready   out  1      block can accept a beat
//  in_bit     in   1      serial data bit (the mux output)
//  in_sel     in   SEL_W  channel index of in_bit (unused when AUTO_SEL=1)
//  ch_strobe  out  N      registered one-hot of channel accepted last cycle (demux output)
//  ch_bit     out  1      registered copy of accepted bit, aligned with ch_strobe
//  out_valid  out  1      out_data holds a complete word
//  out_ready  in   1      downstream accepts word
//  out_data   out  N      reassembled word, bit k = bit received on channel k
//  dup_err    out  1      1-cycle pulse: accepted channel already filled in current word
// BEHAVIOUR
//  - Reset: in_ready=1, ch_strobe=0, ch_bit=0, out_valid=0, out_data=0, dup_err=0; internal
//    shadow word, channel mask and auto counter cleared.
//  - in_ready = !out_valid | out_ready (combinational). Beat accepted when in_valid & in_ready.
//  - Accept, channel s (in_sel or counter): shadow[s]<=in_bit, mask[s]<=1,
//    ch_strobe<=onehot(s), ch_bit<=in_bit; otherwise ch_strobe<=0 next cycle. 1-cycle latency.
//  - Auto counter increments per accepted beat and wraps N-1 -> 0.
//  - dup_err pulses the cycle after an accept where mask[s] was already 1; bit is overwritten.
//  - Completion: accepted beat makes mask all-ones -> next cycle out_data <= shadow with
//    bit s replaced by in_bit, out_valid<=1, mask<=0, shadow<=0. Word out 1 cycle after last bit.
//  - out_valid & out_ready with no new completion -> out_valid<=0; out_data holds its value.
//    Completion in same cycle as drain -> out_valid stays 1 with new word (back-to-back).
//  - out_valid & !out_ready -> in_ready=0, no beats accepted, out_data stable.
//  - flush: mask, shadow, counter <= 0; an accept in the same cycle is dropped (flush wins);
//    out_valid/out_data untouched; ch_strobe<=0.
//  - Async rst mid-word: everything returns to reset values immediately; partial word lost.
//  - Channel order free when AUTO_SEL=0; only all-N coverage completes a word.
// STRUCTURE
//  - Shared package: N/SEL_W defaults, onehot function (SEL_W -> N), used by mux and demux benches.
//  - One sub-module: demux_onehot_dec (SEL_W -> N one-hot decoder, combinational, gated by
//    accept); rest (shadow/mask regs, counter, output register) inline.
// TESTING
//  - AUTO_SEL=0, sel 0..15 in order, bit=~sel[0] (pattern 0x5555) -> out_valid 1 cycle after
//    sel=15, out_data=16'h5555, ch_strobe walks 0x0001..0x8000.
//  - Reverse order sel 15..0, bits of 16'hA3C7 -> out_data=16'hA3C7; no dup_err.
//  - sel 3 sent twice (bit 0 then 1) inside a word -> dup_err pulse once; word bit3=1.
//  - out_ready=0 after first word: second full word sent -> in_ready=0 at 16th... stall held,
//    out_data=first word stable; raise out_ready -> second word completes, no beat lost.
//  - AUTO_SEL=1, 32 beats of 0x5555 then 0xFFFF continuous, out_ready=1 -> two words,
//    counter wraps 15->0.
//  - flush after 7 beats, then full word 0x1234 -> out_data=16'h1234; rst asserted mid-word ->
//    out_valid=0, ch_strobe=0, next full word correct.

Source files
------------

// File: rtl/demux1to16_deframer_pkg.sv
// Shared widths and select helpers for the 16:1 mux / 1:16 demux datapath.
package demux1to16_deframer_pkg;

  localparam int unsigned N_DEF     = 16;
  localparam int unsigned SEL_W_DEF = 4;

  typedef logic [N_DEF-1:0]     word_t;
  typedef logic [SEL_W_DEF-1:0] sel_t;

  function automatic word_t onehot(input sel_t s);
    onehot = word_t'(1) << s;
  endfunction

endpackage

// File: rtl/demux1to16_deframer_onehot_dec.sv
// Select-to-one-hot decoder; all outputs low unless the beat is accepted.
module demux_onehot_dec #(
  parameter int unsigned N     = 16,
  parameter int unsigned SEL_W = 4
) (
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [N-1:0]     hot
);

  always_comb begin
    hot = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (en && (sel == SEL_W'(k))) hot[k] = 1'b1;
    end
  end

endmodule

// File: rtl/demux1to16_deframer.sv
// Serial-to-parallel deframer: demuxes each accepted bit to its channel and
// emits the reassembled word on a valid/ready port once every channel is filled.
module demux1to16_deframer
  import demux1to16_deframer_pkg::*;
#(
  parameter int unsigned N        = N_DEF,
  parameter int unsigned SEL_W    = SEL_W_DEF,
  parameter int unsigned AUTO_SEL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic [SEL_W-1:0] in_sel,
  output logic [N-1:0]     ch_strobe,
  output logic             ch_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             dup_err
);

  logic [N-1:0]     shadow;
  logic [N-1:0]     mask;
  logic [N-1:0]     hot;
  logic [SEL_W-1:0] cnt;
  logic [SEL_W-1:0] sel;
  logic             accept;
  logic             complete;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign sel      = (AUTO_SEL != 0) ? cnt : in_sel;

  demux_onehot_dec #(.N(N), .SEL_W(SEL_W)) u_dec (
    .en  (accept),
    .sel (sel),
    .hot (hot)
  );

  // The completing bit bypasses the shadow so the word leaves one cycle after it.
  assign complete = accept && (&(mask | hot));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow    <= '0;
      mask      <= '0;
      cnt       <= '0;
      ch_strobe <= '0;
      ch_bit    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      dup_err   <= 1'b0;
    end else begin
      ch_strobe <= hot;
      dup_err   <= |(mask & hot);
      if (accept) ch_bit <= in_bit;

      if (out_valid && out_ready) out_valid <= 1'b0;

      if (flush) begin
        shadow <= '0;
        mask   <= '0;
        cnt    <= '0;
      end else if (accept) begin
        cnt <= cnt + SEL_W'(1);
        if (complete) begin
          out_data  <= (shadow & ~hot) | ({N{in_bit}} & hot);
          out_valid <= 1'b1;
          shadow    <= '0;
          mask      <= '0;
        end else begin
          shadow <= (shadow & ~hot) | ({N{in_bit}} & hot);
          mask   <= mask | hot;
        end
      end
    end
  end

endmodule
